// File: rtl/clkgen_pkg.sv
// Shared types and constants for the clkgen_div_bank clock divider / reset sequencer.
package clkgen_pkg;

    localparam int ClkgenMinDiv = 2;
    localparam int ClkgenMaxOut = 8;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        SYNC  = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } rst_state_e;

    // Ratios below the minimum cannot produce a toggling clock, so they fold to divide-by-2.
    function automatic int clkgen_clamp_div(input int n);
        return (n < ClkgenMinDiv) ? ClkgenMinDiv : n;
    endfunction

endpackage

// File: rtl/clkgen_div_bank_if.sv
// Ratio-update handshake between a configuration master and clkgen_div_bank.
interface clkgen_div_bank_if #(
    parameter int NumOut = 2,
    parameter int DivW   = 8
);
    localparam int ChanW = (NumOut > 1) ? $clog2(NumOut) : 1;

    logic             cfg_req_i;
    logic [ChanW-1:0] cfg_chan_i;
    logic [DivW-1:0]  cfg_div_i;
    logic             cfg_busy_o;
    logic             cfg_ack_o;

    modport master (
        output cfg_req_i, cfg_chan_i, cfg_div_i,
        input  cfg_busy_o, cfg_ack_o
    );

    modport slave (
        input  cfg_req_i, cfg_chan_i, cfg_div_i,
        output cfg_busy_o, cfg_ack_o
    );
endinterface

// File: rtl/clkgen_div_chan.sv
// One divider channel: counter, ratio register, enable gating and wrap-boundary ratio load.
// Define CLKGEN_BUFG_EN to drive the output through a BUFG primitive.
module clkgen_div_chan
    import clkgen_pkg::*;
#(
    parameter int DivW       = 8,
    parameter int DefaultDiv = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic            i_load,
    input  logic [DivW-1:0] i_div,
    output logic            o_rdy,
    output logic            o_clk
);
    logic [DivW-1:0] r_cnt;
    logic [DivW-1:0] r_div;
    logic            r_run;
    logic            r_clk;
    logic            w_wrap;
    logic [DivW-1:0] w_half;

    assign w_wrap = r_run && (r_cnt == r_div - DivW'(1));
    assign w_half = (r_div >> 1) + {{(DivW-1){1'b0}}, r_div[0]};
    // A stopped channel can take a new ratio at any edge; a running one only at its wrap.
    assign o_rdy  = !r_run || w_wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_div <= DivW'(DefaultDiv);
            r_run <= 1'b0;
            r_clk <= 1'b0;
        end else begin
            r_clk <= r_run && (r_cnt < w_half);
            if (i_load) begin
                r_div <= DivW'(clkgen_clamp_div(int'(i_div)));
            end
            if (r_run) begin
                if (w_wrap) begin
                    r_cnt <= '0;
                    r_run <= i_en;
                end else begin
                    r_cnt <= r_cnt + DivW'(1);
                end
            end else begin
                r_cnt <= '0;
                r_run <= i_en;
            end
        end
    end

`ifdef CLKGEN_BUFG_EN
    BUFG u_bufg (
        .I (r_clk),
        .O (o_clk)
    );
`else
    assign o_clk = r_clk;
`endif

endmodule

// File: rtl/clkgen_div_bank.sv
// Multi-channel programmable clock divider with ratio-update handshake and stretched system reset.
// Optional CLKGEN_BUFG_EN routes every divided clock through a BUFG (see clkgen_div_chan).
module clkgen_div_bank
    import clkgen_pkg::*;
#(
    parameter int NumOut     = 2,
    parameter int DivW       = 8,
    parameter int DefaultDiv = 4,
    parameter int ResetHold  = 16
) (
    input  logic              io_clk_buf,
    input  logic              IO_RST_N,
    input  logic [NumOut-1:0] en_i,
    clkgen_div_bank_if.slave  cfg,
    output logic [NumOut-1:0] clk_o,
    output logic              rst_sys_n
);
    localparam int ChanW = (NumOut > 1) ? $clog2(NumOut) : 1;
    localparam int HoldW = $clog2(ResetHold + 1);

    logic [1:0]       r_sync;
    logic             w_rst_sync_n;
    rst_state_e       r_state;
    rst_state_e       w_state_nxt;
    logic [HoldW-1:0] r_hold;
    logic [HoldW-1:0] w_hold_nxt;
    logic             r_rst_sys_n;

    logic              r_busy;
    logic              r_ack;
    logic [ChanW-1:0]  r_chan;
    logic [DivW-1:0]   r_div;
    logic              w_accept;
    logic              w_tgt_rdy;
    logic              w_apply;
    logic [NumOut-1:0] w_rdy;
    logic [NumOut-1:0] w_load;

    // Reset release is synchronised; assertion stays asynchronous.
    always_ff @(posedge io_clk_buf or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign w_rst_sync_n = r_sync[1];

    always_ff @(posedge io_clk_buf or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_state     <= RESET;
            r_hold      <= '0;
            r_rst_sys_n <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_rst_sys_n <= (w_state_nxt == RUN);
        end
    end

    // The edge leaving SYNC already counts as the first hold cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        case (r_state)
            RESET: w_state_nxt = SYNC;
            SYNC: begin
                if (w_rst_sync_n) begin
                    if (ResetHold <= 1) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = HOLD;
                        w_hold_nxt  = HoldW'(1);
                    end
                end
            end
            HOLD: begin
                if (r_hold == HoldW'(ResetHold - 1)) begin
                    w_state_nxt = RUN;
                end else begin
                    w_hold_nxt = r_hold + HoldW'(1);
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = RESET;
        endcase
    end

    assign w_accept = cfg.cfg_req_i && !r_busy;

    // An out-of-range channel matches nothing, so it stays ready and acks with no load.
    always_comb begin
        w_tgt_rdy = 1'b1;
        for (int k = 0; k < NumOut; k++) begin
            if (r_chan == ChanW'(k)) begin
                w_tgt_rdy = w_rdy[k];
            end
        end
    end

    assign w_apply = r_busy && !r_ack && w_tgt_rdy;

    always_comb begin
        w_load = '0;
        for (int k = 0; k < NumOut; k++) begin
            if (r_chan == ChanW'(k)) begin
                w_load[k] = w_apply;
            end
        end
    end

    always_ff @(posedge io_clk_buf or negedge w_rst_sync_n) begin
        if (!w_rst_sync_n) begin
            r_busy <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_ack <= w_apply;
            if (r_ack) begin
                r_busy <= 1'b0;
            end else if (w_accept) begin
                r_busy <= 1'b1;
            end
        end
    end

    always_ff @(posedge io_clk_buf) begin
        if (w_accept) begin
            r_chan <= cfg.cfg_chan_i;
            r_div  <= cfg.cfg_div_i;
        end
    end

    for (genvar k = 0; k < NumOut; k++) begin : g_chan
        clkgen_div_chan #(
            .DivW       (DivW),
            .DefaultDiv (DefaultDiv)
        ) u_chan (
            .i_clk   (io_clk_buf),
            .i_rst_n (w_rst_sync_n),
            .i_en    (en_i[k]),
            .i_load  (w_load[k]),
            .i_div   (r_div),
            .o_rdy   (w_rdy[k]),
            .o_clk   (clk_o[k])
        );
    end

    assign cfg.cfg_busy_o = r_busy;
    assign cfg.cfg_ack_o  = r_ack;
    assign rst_sys_n      = r_rst_sys_n;

endmodule

// File: tb/tb_clkgen_div_bank.sv
// Self-checking bench for clkgen_div_bank: directed ratio table, corner sequences, random run vs model.
module tb_clkgen_div_bank;
    localparam int NUM = 2;
    localparam int DW  = 8;
    localparam int DEF = 4;
    localparam int RH  = 16;

    logic           io_clk_buf = 1'b0;
    logic           IO_RST_N;
    logic [NUM-1:0] en_i;
    logic [NUM-1:0] clk_o;
    logic           rst_sys_n;

    int n_chk  = 0;
    int n_fail = 0;

    clkgen_div_bank_if #(.NumOut(NUM), .DivW(DW)) cfg_if ();

    clkgen_div_bank #(
        .NumOut     (NUM),
        .DivW       (DW),
        .DefaultDiv (DEF),
        .ResetHold  (RH)
    ) dut (
        .io_clk_buf (io_clk_buf),
        .IO_RST_N   (IO_RST_N),
        .en_i       (en_i),
        .cfg        (cfg_if),
        .clk_o      (clk_o),
        .rst_sys_n  (rst_sys_n)
    );

    always #5 io_clk_buf = ~io_clk_buf;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int ch;
        int div;
        int hi;
        int per;
    } vec_t;

    // Reference model state: per-channel period progress and the pending update.
    int m_e;
    bit m_rst;
    bit m_run [NUM];
    int m_el  [NUM];
    int m_n   [NUM];
    bit m_clk [NUM];
    bit m_busy, m_ack;
    int m_chan, m_div;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge io_clk_buf);
    endtask

    task automatic send_req(input int ch, input int div);
        cfg_if.cfg_req_i  = 1'b1;
        cfg_if.cfg_chan_i = 1'(ch);
        cfg_if.cfg_div_i  = DW'(div);
        step();
        cfg_if.cfg_req_i  = 1'b0;
    endtask

    task automatic wait_not_busy();
        for (int i = 0; i < 300; i++) begin
            if (!cfg_if.cfg_busy_o) break;
            step();
        end
    endtask

    task automatic wait_ack(output int lat);
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (cfg_if.cfg_ack_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic find_rise(input int ch, output bit ok);
        bit prev;
        ok   = 1'b0;
        prev = clk_o[ch];
        for (int i = 0; i < 600; i++) begin
            step();
            if (!prev && clk_o[ch]) begin
                ok = 1'b1;
                break;
            end
            prev = clk_o[ch];
        end
    endtask

    task automatic measure(input int ch, output int hi, output int per);
        bit ok;
        int lo;
        find_rise(ch, ok);
        hi = -1;
        per = -1;
        if (ok) begin
            hi = 1;
            lo = 0;
            for (int i = 0; i < 300; i++) begin
                step();
                if (clk_o[ch]) begin
                    if (lo == 0) hi++;
                    else break;
                end else begin
                    lo++;
                end
            end
            per = hi + lo;
        end
    endtask

    task automatic model_init();
        m_e = 0;
        m_rst = 1'b0;
        m_busy = 1'b0;
        m_ack = 1'b0;
        m_chan = 0;
        m_div = 0;
        for (int k = 0; k < NUM; k++) begin
            m_run[k] = 1'b0;
            m_el[k]  = 0;
            m_n[k]   = DEF;
            m_clk[k] = 1'b0;
        end
    endtask

    // One io_clk_buf edge of the behavioural model, using inputs stable before the edge.
    task automatic model_step();
        bit rdy [NUM];
        bit apply;
        int ach, adiv;
        m_e++;
        m_rst = (m_e >= 2 + RH);
        if (m_e <= 2) return;
        for (int k = 0; k < NUM; k++) rdy[k] = !m_run[k] || (m_el[k] == m_n[k] - 1);
        apply = m_busy && !m_ack && (m_chan >= NUM || rdy[m_chan]);
        ach = m_chan;
        adiv = m_div;
        for (int k = 0; k < NUM; k++) m_clk[k] = m_run[k] && (m_el[k] < (m_n[k] + 1) / 2);
        if (m_ack) begin
            m_busy = 1'b0;
        end else if (cfg_if.cfg_req_i && !m_busy) begin
            m_busy = 1'b1;
            m_chan = int'(cfg_if.cfg_chan_i);
            m_div  = int'(cfg_if.cfg_div_i);
        end
        m_ack = apply;
        for (int k = 0; k < NUM; k++) begin
            if (m_run[k] && m_el[k] != m_n[k] - 1) begin
                m_el[k]++;
            end else begin
                m_el[k]  = 0;
                m_run[k] = en_i[k];
            end
            if (apply && ach == k) m_n[k] = (adiv < 2) ? 2 : adiv;
        end
    endtask

    initial begin
        vec_t tbl [7];
        int lat, hi, per, acks;
        bit exp_seq [8];
        logic [NUM+2:0] exp_v;

        tbl = '{'{1, 5, 3, 5}, '{0, 0, 1, 2}, '{0, 1, 1, 2}, '{1, 7, 4, 7},
                '{0, 3, 2, 3}, '{0, 4, 2, 4}, '{1, 4, 2, 4}};

        IO_RST_N = 1'b0;
        en_i = '1;
        cfg_if.cfg_req_i = 1'b0;
        cfg_if.cfg_chan_i = '0;
        cfg_if.cfg_div_i = '0;
        repeat (4) step();
        chk("reset clk_o", 32'(clk_o), 0);
        chk("reset busy", 32'(cfg_if.cfg_busy_o), 0);
        chk("reset ack", 32'(cfg_if.cfg_ack_o), 0);
        chk("reset rst_sys_n", 32'(rst_sys_n), 0);

        // Reset release: sequencer timing and phase-aligned start.
        IO_RST_N = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 17 || i == 18 || i == 20) chk("rst_sys_n release", 32'(rst_sys_n), 32'(i >= 18));
            if (i >= 3 && i <= 12)
                chk("clk_o after release", 32'(clk_o), (i >= 4 && ((i - 4) % 4) < 2) ? 32'h3 : 32'h0);
        end

        // Ratio table, including odd ratio and clamp.
        for (int t = 0; t < 7; t++) begin
            wait_not_busy();
            send_req(tbl[t].ch, tbl[t].div);
            wait_ack(lat);
            chk("tbl ack seen", 32'(lat > 0), 1);
            measure(tbl[t].ch, hi, per);
            chk("tbl high time", 32'(hi), 32'(tbl[t].hi));
            chk("tbl period", 32'(per), 32'(tbl[t].per));
        end

        // Enable drop mid-period, then reassert.
        find_rise(0, exp_seq[0]);
        en_i[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("en drop clk_o[0]", 32'(clk_o[0]), 32'(i == 0));
        end
        en_i[0] = 1'b1;
        exp_seq = '{0, 1, 1, 0, 0, 1, 1, 0};
        for (int i = 0; i < 8; i++) begin
            step();
            chk("en reassert clk_o[0]", 32'(clk_o[0]), 32'(exp_seq[i]));
        end

        // Update to a stopped channel acks one cycle after acceptance.
        en_i[1] = 1'b0;
        repeat (10) step();
        send_req(1, 3);
        chk("stopped busy", 32'({cfg_if.cfg_busy_o, cfg_if.cfg_ack_o}), 32'b10);
        step();
        chk("stopped ack", 32'(cfg_if.cfg_ack_o), 1);
        step();
        chk("stopped ack done", 32'({cfg_if.cfg_busy_o, cfg_if.cfg_ack_o}), 32'b00);
        en_i[1] = 1'b1;
        exp_seq = '{0, 1, 1, 0, 1, 1, 0, 1};
        for (int i = 0; i < 7; i++) begin
            step();
            chk("stopped restart clk_o[1]", 32'(clk_o[1]), 32'(exp_seq[i]));
        end

        // Second request while busy is dropped.
        wait_not_busy();
        send_req(0, 6);
        chk("busy after accept", 32'(cfg_if.cfg_busy_o), 1);
        acks = 0;
        send_req(0, 3);
        acks += int'(cfg_if.cfg_ack_o);
        for (int i = 0; i < 20; i++) begin
            step();
            acks += int'(cfg_if.cfg_ack_o);
        end
        chk("single ack", 32'(acks), 1);
        measure(0, hi, per);
        chk("busy ignored high", 32'(hi), 3);
        chk("busy ignored period", 32'(per), 6);

        // Reset during a pending update.
        wait_not_busy();
        send_req(0, 9);
        #2 IO_RST_N = 1'b0;
        #1;
        chk("midreset outputs", 32'({clk_o, cfg_if.cfg_busy_o, cfg_if.cfg_ack_o, rst_sys_n}), 0);
        repeat (3) step();
        IO_RST_N = 1'b1;
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            acks += int'(cfg_if.cfg_ack_o);
        end
        chk("midreset no ack", 32'(acks), 0);
        measure(0, hi, per);
        chk("midreset ch0 high", 32'(hi), 2);
        chk("midreset ch0 period", 32'(per), 4);
        measure(1, hi, per);
        chk("midreset ch1 period", 32'(per), 4);

        // Randomised run against the reference model from a fresh reset.
        IO_RST_N = 1'b0;
        en_i = '1;
        cfg_if.cfg_req_i = 1'b0;
        repeat (3) step();
        model_init();
        IO_RST_N = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge io_clk_buf);
            model_step();
            @(negedge io_clk_buf);
            for (int k = 0; k < NUM; k++) exp_v[k + 3] = m_clk[k];
            exp_v[2] = m_busy;
            exp_v[1] = m_ack;
            exp_v[0] = m_rst;
            chk("random outputs", 32'({clk_o, cfg_if.cfg_busy_o, cfg_if.cfg_ack_o, rst_sys_n}), 32'(exp_v));
            for (int k = 0; k < NUM; k++)
                if ($urandom_range(19) == 0) en_i[k] = ~en_i[k];
            cfg_if.cfg_req_i  = ($urandom_range(4) == 0);
            cfg_if.cfg_chan_i = 1'($urandom_range(1));
            cfg_if.cfg_div_i  = DW'($urandom_range(11));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clkgen_div_bank.md
# clkgen_div_bank

Parametrised multi-channel clock divider and reset sequencer for the FPGA top-level clock generator. It derives `NumOut` divided clocks from the buffered board clock `io_clk_buf`, each with a runtime-programmable integer ratio that changes glitch-free at period boundaries. It also produces a synchronised, stretched system reset. It sits between the board clock input buffer and the system/peripheral clock consumers, replacing fixed toggle-flop dividers.

## Interface
- `NumOut`, default 2, number of divided clock channels (1..8).
- `DivW`, default 8, width of the divide-ratio field.
- `DefaultDiv`, default 4, ratio loaded into every channel at reset (2..2^DivW-1).
- `ResetHold`, default 16, `io_clk_buf` cycles `rst_sys_n` stays low after the synchronised deassertion of `IO_RST_N`.
- `io_clk_buf` in 1: reference clock; all logic is clocked on its rising edge.
- `IO_RST_N` in 1: asynchronous, active-low reset.
- `en_i` in NumOut: per-channel run enable.
- `cfg_req_i` in 1: ratio update request, single-cycle pulse.
- `cfg_chan_i` in $clog2(NumOut) (min 1): target channel.
- `cfg_div_i` in DivW: new ratio N.
- `cfg_busy_o` out 1: update pending.
- `cfg_ack_o` out 1: one-cycle pulse when the update is applied.
- `clk_o` out NumOut: divided clocks.
- `rst_sys_n` out 1: system reset, active low.

## Operation
- Each channel has:
  - a counter `cnt` (DivW bits) running 0..N-1 and wrapping;
  - a registered output, high while `cnt` < ceil(N/2).
- Period is exactly N `io_clk_buf` cycles; high time is ceil(N/2) cycles, so even N gives 50% duty.
- An effective ratio N < 2 is clamped to 2, so `cfg_div_i` = 0 or 1 gives divide-by-2.
- Wrap cycle: the cycle in which `cnt` == N-1.
- Enable:
  - Deasserting `en_i[k]` takes effect at the channel's next wrap. `clk_o[k]` is then held 0 and `cnt` held 0.
  - Reasserting `en_i[k]` starts a new period with `cnt` = 0 on the next cycle.
  - A period already in progress is never truncated.
- Update handshake:
  - `cfg_req_i` is accepted only while `cfg_busy_o` = 0. Requests while busy are ignored and are not queued.
  - On acceptance, channel and ratio are latched and `cfg_busy_o` rises the next cycle.
  - The new N is loaded at the target channel's next wrap. `cfg_ack_o` pulses in that cycle, and `cfg_busy_o` falls the following cycle.
  - If the target channel is stopped, the new N loads one cycle after acceptance.
  - `cfg_chan_i` ≥ NumOut: the request is accepted, acked after one cycle, and has no effect.
- Reset sequencer:
  - Assertion of `IO_RST_N` forces `rst_sys_n` low asynchronously.
  - Deassertion passes through a 2-flop synchroniser, then a hold counter. `rst_sys_n` rises after ResetHold further cycles.
  - States: RESET, SYNC, HOLD, RUN.
  - Dividers run from the synchronised reset, not from `rst_sys_n`.

## Timing
- Reset values:
  - `clk_o` = 0 for all channels.
  - `cnt` = 0.
  - N = DefaultDiv.
  - `cfg_busy_o` = 0, `cfg_ack_o` = 0, `rst_sys_n` = 0.
- After the synchronised reset release:
  - All enabled channels start together on the same cycle, so channels with equal N are phase-aligned.
  - First rising edge of `clk_o` is 1 cycle after start.
- `rst_sys_n` rises at cycle 2+ResetHold after the first `io_clk_buf` edge following `IO_RST_N` deassertion.
- Update latency is 1 to N+1 cycles from request to ack.
- Update and enable-deassert arriving on the same wrap:
  - The new N is loaded and the channel stops.
  - The next enable starts with the new N.
- Reset asserted mid-update: the update is discarded.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- `CLKGEN_BUFG_EN` defined: each `clk_o[k]` is driven through a BUFG primitive.
- Not defined: `clk_o[k]` is the flop output directly. Use this for simulation and non-Xilinx lint.
- Cycle behaviour is identical in both cases.

## Structure
- Package `clkgen_pkg` holds:
  - the reset sequencer state enum (RESET/SYNC/HOLD/RUN);
  - constants `ClkgenMinDiv` = 2 and `ClkgenMaxOut` = 8.
- Sub-module `clkgen_div_chan` contains one channel: counter, ratio register, enable gating, wrap-boundary load, and BUFG option. It is instantiated NumOut times with a generate loop.
- The top level holds the config handshake and the reset sequencer.

## Test plan
All scenarios use NumOut=2, DivW=8, DefaultDiv=4, ResetHold=16.
- **Reset release:** release `IO_RST_N` → `rst_sys_n` rises at cycle 18; both `clk_o` have period 4, high 2 cycles, and are in phase.
- **Odd ratio:** request ch1, N=5 → ack at ch1's wrap; from the next period, `clk_o[1]` has period 5, high 3 / low 2, with no runt pulse.
- **Clamp:** request ch0, N=0 → ch0 has period 2; request N=1 → period 2.
- **Enable:** drop `en_i[0]` mid-period → current period completes, then `clk_o[0]` is held 0; reassert → first high on the 2nd cycle.
- **Busy:** second request while `cfg_busy_o`=1 → ignored, with exactly one ack; request to stopped ch1 → ack 1 cycle after acceptance.
- **Mid-operation reset:** assert `IO_RST_N` during a pending update → all outputs return to reset values immediately and N returns to 4.
